motor_contrl: RTL and testbench

- Motor-drive controller for the navigation/scanner platform.
- Converts a heading correction (geo_in), a GPS correction (gps_in) and a QR-code detect flag (QR_in) into a 4-phase stepper coil pattern (M_OUT) and a continuous-rotation motor enable (ro_motor).
- Steps are paced by the external PWM step-rate input and gated by EN.
- Sits between the sensor/decoder front-end and the motor driver stage.

---
 rtl/motor_contrl_if.sv | 17 +
 rtl/motor_contrl.sv | 121 ++++++++++++
 tb/tb_motor_contrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/motor_contrl_if.sv
// Command and status bundle between the sensor/decoder front-end, the motor
// controller and the motor driver stage.
interface motor_contrl_if;
    logic       PWM;
    logic       EN;
    logic       DIR;
    logic       QR_in;
    logic [7:0] geo_in;
    logic [7:0] gps_in;
    logic       ro_motor;
    logic [3:0] M_OUT;

    modport master (output PWM, EN, DIR, QR_in, geo_in, gps_in,
                    input  ro_motor, M_OUT);
    modport slave  (input  PWM, EN, DIR, QR_in, geo_in, gps_in,
                    output ro_motor, M_OUT);
endinterface

// File: rtl/motor_contrl.sv
// Stepper/rotation motor controller: turns heading/GPS step commands and a QR
// detect flag into a one-hot full-step coil pattern paced by the PWM strobe.
//
// state    | meaning
// ST_DIS   | EN low: coils off, phase and remaining count frozen
// ST_IDLE  | EN high, nothing to do: coils hold the current phase
// ST_COUNT | EN high, stepping down a captured step count
// ST_QR    | EN high, QR detected: free-running rotation, ro_motor on
module motor_contrl #(
    parameter int STEP_W = 7
) (
    input  logic          clk,
    input  logic          RST,
    motor_contrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_DIS   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_COUNT = 2'd2,
        ST_QR    = 2'd3
    } mode_t;

    mode_t             state;
    mode_t             state_nxt;
    logic [2:0]        pwm_sync;
    logic              step_tick;
    logic [STEP_W:0]   geo_sh;
    logic [STEP_W:0]   gps_sh;
    logic              geo_chg;
    logic              gps_chg;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] remaining_nxt;
    logic              dir;
    logic              dir_nxt;
    logic [1:0]        phase;
    logic [1:0]        phase_nxt;
    logic [3:0]        m_out;
    logic [3:0]        m_out_nxt;
    logic              advance;
    logic              reverse;

    // pwm_sync[1] is the synchronised PWM, pwm_sync[2] its previous value
    assign step_tick = pwm_sync[1] & ~pwm_sync[2];
    assign geo_chg   = (bus.geo_in[STEP_W:0] != geo_sh);
    assign gps_chg   = (bus.gps_in[STEP_W:0] != gps_sh);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= ST_DIS;
            pwm_sync  <= '0;
            geo_sh    <= '0;
            gps_sh    <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            phase     <= 2'd0;
            m_out     <= 4'b0000;
        end else begin
            state     <= state_nxt;
            pwm_sync  <= {pwm_sync[1:0], bus.PWM};
            geo_sh    <= bus.geo_in[STEP_W:0];
            gps_sh    <= bus.gps_in[STEP_W:0];
            remaining <= remaining_nxt;
            dir       <= dir_nxt;
            phase     <= phase_nxt;
            m_out     <= m_out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        dir_nxt       = dir;
        phase_nxt     = phase;
        m_out_nxt     = 4'b0000;
        advance       = 1'b0;
        reverse       = 1'b0;

        if (bus.EN) begin
            if (bus.QR_in) begin
                advance = step_tick;
                reverse = bus.DIR;
            end else if (remaining != '0) begin
                advance = step_tick;
                reverse = dir;
                if (step_tick) begin
                    remaining_nxt = remaining - STEP_W'(1);
                end
            end
        end

        if (advance) begin
            phase_nxt = reverse ? (phase - 2'd1) : (phase + 2'd1);
        end

        // A fresh command replaces any count in flight; phase is left alone
        if (geo_chg) begin
            remaining_nxt = bus.geo_in[STEP_W-1:0];
            dir_nxt       = bus.geo_in[STEP_W] ^ bus.DIR;
        end else if (gps_chg) begin
            remaining_nxt = bus.gps_in[STEP_W-1:0];
            dir_nxt       = bus.DIR;
        end

        if (!bus.EN) begin
            state_nxt = ST_DIS;
        end else if (bus.QR_in) begin
            state_nxt = ST_QR;
        end else if (remaining_nxt != '0) begin
            state_nxt = ST_COUNT;
        end else begin
            state_nxt = ST_IDLE;
        end

        if (bus.EN) begin
            m_out_nxt = 4'b0001 << phase_nxt;
        end
    end

    assign bus.ro_motor = (state == ST_QR);
    assign bus.M_OUT    = m_out;
endmodule

// File: tb/tb_motor_contrl.sv
// Directed plus randomized bench for motor_contrl; a per-step model tracks
// coil phase, remaining steps and direction from the command rules.
module tb_motor_contrl;
    logic clk;
    logic RST;

    motor_contrl_if bus ();

    motor_contrl #(.STEP_W(7)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // reference model state
    int         m_phase = 0;
    int         m_rem   = 0;
    bit         m_dir   = 1'b0;
    logic [7:0] m_geo_sh = 8'h00;
    logic [7:0] m_gps_sh = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_mout();
        return bus.EN ? (8'h01 << m_phase) : 8'h00;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_m_out"}, {4'h0, bus.M_OUT}, exp_mout());
        check({tag, "_ro"}, {7'h0, bus.ro_motor}, {7'h0, bus.EN & bus.QR_in});
    endtask

    task automatic model_step();
        if (bus.EN && bus.QR_in) begin
            m_phase = (m_phase + (bus.DIR ? 3 : 1)) % 4;
        end else if (bus.EN && m_rem > 0) begin
            m_phase = (m_phase + (m_dir ? 3 : 1)) % 4;
            m_rem--;
        end
    endtask

    task automatic pulse(input string tag);
        int hi;
        int lo;
        hi = $urandom_range(1, 3);
        lo = $urandom_range(4, 7);
        bus.PWM = 1'b1;
        repeat (hi) @(negedge clk);
        bus.PWM = 1'b0;
        repeat (lo) @(negedge clk);
        model_step();
        check_outputs(tag);
    endtask

    task automatic pulses(input int n, input string tag);
        for (int i = 0; i < n; i++) pulse(tag);
    endtask

    task automatic set_cmd(input logic [7:0] geo, input logic [7:0] gps);
        bus.geo_in = geo;
        bus.gps_in = gps;
        if (geo != m_geo_sh) begin
            m_rem = int'(geo[6:0]);
            m_dir = geo[7] ^ bus.DIR;
        end else if (gps != m_gps_sh) begin
            m_rem = int'(gps[6:0]);
            m_dir = bus.DIR;
        end
        m_geo_sh = geo;
        m_gps_sh = gps;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_en(input logic v, input string tag);
        bus.EN = v;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_qr(input logic v, input string tag);
        bus.QR_in = v;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_rem    = 0;
        m_dir    = 1'b0;
        m_geo_sh = 8'h00;
        m_gps_sh = 8'h00;
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] p;

        RST        = 1'b1;
        bus.PWM    = 1'b0;
        bus.EN     = 1'b0;
        bus.DIR    = 1'b0;
        bus.QR_in  = 1'b0;
        bus.geo_in = 8'h00;
        bus.gps_in = 8'h00;

        // reset held with PWM toggling
        for (int i = 0; i < 10; i++) begin
            bus.PWM = ~bus.PWM;
            @(negedge clk);
            if (i == 4 || i == 9) check_outputs("reset");
        end
        bus.PWM = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        pulses(3, "rst_release_dis");

        // geo forward 70 steps, then hold
        set_en(1'b1, "en_on_idle");
        set_cmd(8'h46, 8'h00);
        pulses(70, "geo_fwd");
        pulses(3, "geo_fwd_hold");

        // geo reverse
        set_cmd(8'hC6, 8'h00);
        pulses(70, "geo_rev");
        pulses(2, "geo_rev_hold");

        // DIR invert makes the reverse command step forward
        bus.DIR = 1'b1;
        set_cmd(8'h00, 8'h00);
        set_cmd(8'hC6, 8'h00);
        pulses(70, "geo_rev_dirinv");
        pulses(2, "geo_rev_dirinv_hold");
        bus.DIR = 1'b0;

        // zero step count is no motion
        set_cmd(8'h80, 8'h00);
        pulses(2, "geo_zero");

        // enable gating mid-count
        set_cmd(8'h46, 8'h00);
        pulses(10, "gate_pre");
        set_en(1'b0, "gate_off");
        pulses(5, "gate_paused");
        set_en(1'b1, "gate_on");
        pulses(60, "gate_resume");
        pulses(2, "gate_hold");

        // GPS is always forward
        set_cmd(8'h46, 8'hC6);
        pulses(70, "gps_c6");
        set_cmd(8'h46, 8'h46);
        pulses(70, "gps_46");
        pulses(2, "gps_hold");

        // simultaneous change: geo wins
        set_cmd(8'h85, 8'h0A);
        pulses(8, "geo_gps_same_clk");

        // randomized commands, direction and enable
        for (int k = 0; k < 8; k++) begin
            bus.DIR = 1'($urandom_range(0, 1));
            g = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 20))};
            p = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 20))};
            if ($urandom_range(0, 1) == 0) set_cmd(g, m_gps_sh);
            else if ($urandom_range(0, 1) == 0) set_cmd(m_geo_sh, p);
            else set_cmd(g, p);
            for (int j = 0; j < 24; j++) begin
                bus.EN = ($urandom_range(0, 4) != 0);
                @(negedge clk);
                pulse("rand");
            end
        end
        bus.DIR = 1'b0;
        set_en(1'b1, "rand_end_en");

        // QR constant rotation beyond any count
        set_qr(1'b1, "qr_on");
        pulses(20, "qr_fwd");
        bus.DIR = 1'b1;
        pulses(8, "qr_rev");
        set_cmd(8'h03, m_gps_sh);
        pulses(6, "qr_cmd_held");
        set_qr(1'b0, "qr_off");
        pulses(5, "qr_off_count");
        bus.DIR = 1'b0;
        set_qr(1'b1, "qr_on2");
        pulses(3, "qr_fwd2");
        bus.QR_in = 1'b0;
        set_en(1'b0, "qr_en_off");
        pulses(2, "qr_en_off_paused");

        // reset mid-count loses pending steps
        set_en(1'b1, "pre_rst_en");
        set_cmd(8'h20, m_gps_sh);
        pulses(5, "pre_rst_count");
        bus.geo_in = 8'h00;
        bus.gps_in = 8'h00;
        RST = 1'b1;
        model_reset();
        @(negedge clk);
        check({"mid_rst", "_m_out"}, {4'h0, bus.M_OUT}, 8'h00);
        check({"mid_rst", "_ro"}, {7'h0, bus.ro_motor}, 8'h00);
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        check_outputs("post_rst_en");
        pulses(3, "post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
